// File: rtl/pll_lock_counter_if.sv
// Handshake/bus bundle for pll_lock_counter: lock/count controls in, count/status out.
interface pll_lock_counter_if #(
   parameter int WIDTH = 4
);
   logic             lock;
   logic             clken;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             clr_lost;
   logic [WIDTH-1:0] q;
   logic             locked;
   logic             tc;
   logic             lock_lost;

   // Master drives the controls and observes the counter.
   modport master (
      output lock, clken, up_dn, load, load_val, clr_lost,
      input  q, locked, tc, lock_lost
   );

   // Slave is the counter itself.
   modport slave (
      input  lock, clken, up_dn, load, load_val, clr_lost,
      output q, locked, tc, lock_lost
   );
endinterface

// File: rtl/pll_lock_counter.sv
// Lock-qualified up/down counter. It sits in the PLL output clock domain and
// only counts after the synchronised PLL lock has been high for LOCK_CYCLES
// consecutive samples. It provides load, wrap/saturate, a terminal-count pulse
// and a sticky lock-loss flag.
module pll_lock_counter #(
   parameter int WIDTH       = 4,
   parameter int LOCK_CYCLES = 16,
   parameter int SATURATE    = 0
) (
   input logic              clk,
   input logic              rst,
   pll_lock_counter_if.slave bus
);

   localparam int                SW          = $clog2(LOCK_CYCLES) + 1;
   localparam logic [SW-1:0]     SETTLE_LAST = SW'(LOCK_CYCLES - 1);
   localparam logic [WIDTH-1:0]  ALL_ONES    = '1;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      SETTLING = 2'd1,
      LOCKED   = 2'd2
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [SW-1:0]    r_settle, w_settle_nxt;
   logic             r_lock_m, r_lock_s;
   logic             r_scken;
   logic [WIDTH-1:0] r_q, w_q_nxt;
   logic             r_tc, w_tc_nxt;
   logic             r_lost;
   logic             w_locked, w_lose, w_count, w_at_limit;

   // Two-flop synchroniser; the raw lock is asynchronous to the PLL clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lock_m <= 1'b0;
         r_lock_s <= 1'b0;
      end else begin
         r_lock_m <= bus.lock;
         r_lock_s <= r_lock_m;
      end
   end

   // FSM state register together with its settle counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= UNLOCKED;
         r_settle <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_settle <= w_settle_nxt;
      end
   end

   // Next state: any low sample before qualification completes restarts it.
   always_comb begin
      w_state_nxt  = r_state;
      w_settle_nxt = r_settle;
      case (r_state)
         UNLOCKED: begin
            if (r_lock_s) begin
               w_state_nxt  = SETTLING;
               w_settle_nxt = SW'(1);
            end
         end
         SETTLING: begin
            if (!r_lock_s) begin
               w_state_nxt  = UNLOCKED;
               w_settle_nxt = '0;
            end else if (r_settle == SETTLE_LAST) begin
               w_state_nxt  = LOCKED;
            end else begin
               w_settle_nxt = r_settle + SW'(1);
            end
         end
         LOCKED: begin
            if (!r_lock_s) begin
               w_state_nxt  = UNLOCKED;
               w_settle_nxt = '0;
            end
         end
         default: begin
            w_state_nxt  = UNLOCKED;
            w_settle_nxt = '0;
         end
      endcase
   end

   // FSM outputs: qualified lock, the lock-drop event and the count strobe.
   always_comb begin
      w_locked = (r_state == LOCKED);
      w_lose   = (r_state == LOCKED) && !r_lock_s;
      w_count  = r_scken && (r_state == LOCKED);
   end

   // Next counter value and terminal count. Load beats count beats hold.
   always_comb begin
      w_q_nxt    = r_q;
      w_tc_nxt   = 1'b0;
      w_at_limit = bus.up_dn ? (r_q == ALL_ONES) : (r_q == '0);
      if (bus.load) begin
         w_q_nxt = bus.load_val;
      end else if (w_count) begin
         w_tc_nxt = w_at_limit;
         if (!(w_at_limit && (SATURATE != 0)))
            w_q_nxt = bus.up_dn ? r_q + WIDTH'(1) : r_q - WIDTH'(1);
      end
   end

   // Counter, terminal-count pulse and registered count enable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_q     <= '0;
         r_tc    <= 1'b0;
         r_scken <= 1'b0;
      end else begin
         r_q     <= w_q_nxt;
         r_tc    <= w_tc_nxt;
         r_scken <= w_locked && bus.clken;
      end
   end

   // Sticky lock-loss flag; a new loss beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_lost <= 1'b0;
      else if (w_lose)
         r_lost <= 1'b1;
      else if (bus.clr_lost)
         r_lost <= 1'b0;
   end

   assign bus.q         = r_q;
   assign bus.locked    = w_locked;
   assign bus.tc        = r_tc;
   assign bus.lock_lost = r_lost;

endmodule

// File: tb/tb_pll_lock_counter.sv
// Randomised bench for pll_lock_counter: one wrapping and one saturating
// instance share the stimulus and are compared each cycle against a
// behavioural model.
module tb_pll_lock_counter;

   localparam int W    = 4;
   localparam int LC   = 16;
   localparam int MAXV = (1 << W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic         t_lock = 0, t_clken = 0, t_up = 1, t_load = 0, t_clr = 0;
   logic [W-1:0] t_lval = '0;

   pll_lock_counter_if #(.WIDTH(W)) bus0 ();
   pll_lock_counter_if #(.WIDTH(W)) bus1 ();

   assign bus0.lock = t_lock;  assign bus1.lock = t_lock;
   assign bus0.clken = t_clken; assign bus1.clken = t_clken;
   assign bus0.up_dn = t_up;   assign bus1.up_dn = t_up;
   assign bus0.load = t_load;  assign bus1.load = t_load;
   assign bus0.load_val = t_lval; assign bus1.load_val = t_lval;
   assign bus0.clr_lost = t_clr; assign bus1.clr_lost = t_clr;

   pll_lock_counter #(.WIDTH(W), .LOCK_CYCLES(LC), .SATURATE(0)) u_wrap (
      .clk(clk), .rst(rst), .bus(bus0.slave));
   pll_lock_counter #(.WIDTH(W), .LOCK_CYCLES(LC), .SATURATE(1)) u_sat (
      .clk(clk), .rst(rst), .bus(bus1.slave));

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   // Model: lock history as a run length of high synchronised samples.
   int m_q [2];
   bit m_tc[2];
   bit m_s1, m_s2, m_locked, m_scken, m_lost;
   int m_run;

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin m_q[i] = 0; m_tc[i] = 0; end
      m_s1 = 0; m_s2 = 0; m_locked = 0; m_scken = 0; m_lost = 0; m_run = 0;
   endtask

   task automatic model_step();
      bit locked_prev = m_locked;
      bit do_cnt      = m_scken && locked_prev;
      for (int i = 0; i < 2; i++) begin
         m_tc[i] = 0;
         if (t_load) m_q[i] = int'(t_lval);
         else if (do_cnt) begin
            if (t_up) begin
               if (m_q[i] == MAXV) begin m_tc[i] = 1; m_q[i] = (i == 1) ? MAXV : 0; end
               else m_q[i] = m_q[i] + 1;
            end else begin
               if (m_q[i] == 0) begin m_tc[i] = 1; m_q[i] = (i == 1) ? 0 : MAXV; end
               else m_q[i] = m_q[i] - 1;
            end
         end
      end
      m_run    = m_s2 ? ((m_run < LC) ? m_run + 1 : m_run) : 0;
      m_locked = (m_run >= LC);
      if (locked_prev && !m_locked) m_lost = 1;
      else if (t_clr) m_lost = 0;
      m_scken = locked_prev && t_clken;
      m_s2 = m_s1;
      m_s1 = t_lock;
   endtask

   task automatic check_all();
      chk("q_wrap",      int'(bus0.q),         m_q[0]);
      chk("q_sat",       int'(bus1.q),         m_q[1]);
      chk("tc_wrap",     int'(bus0.tc),        int'(m_tc[0]));
      chk("tc_sat",      int'(bus1.tc),        int'(m_tc[1]));
      chk("locked_wrap", int'(bus0.locked),    int'(m_locked));
      chk("locked_sat",  int'(bus1.locked),    int'(m_locked));
      chk("lost_wrap",   int'(bus0.lock_lost), int'(m_lost));
      chk("lost_sat",    int'(bus1.lock_lost), int'(m_lost));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   // Lock mostly high for long stretches, with short glitches and drops.
   int lock_hold = 0;
   task automatic drive_random();
      if (lock_hold == 0) begin
         t_lock    = ~t_lock;
         lock_hold = t_lock ? int'($urandom_range(30, 250))
                            : (($urandom_range(0, 2) == 0) ? int'($urandom_range(4, 25))
                                                           : int'($urandom_range(1, 2)));
      end
      lock_hold--;
      t_clken = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) t_up = ~t_up;
      t_load = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
         0:       t_lval = '0;
         1:       t_lval = W'(MAXV);
         default: t_lval = W'($urandom_range(0, MAXV));
      endcase
      t_clr = ($urandom_range(0, 29) == 0);
   endtask

   int first_lock;

   initial begin
      model_reset();
      #12;
      check_all();

      // Clean qualification: lock already high when reset releases.
      @(negedge clk);
      t_lock = 1; rst = 1;
      first_lock = -1;
      for (int e = 0; e < 30; e++) begin
         cycle();
         if (first_lock < 0 && bus0.locked) first_lock = e;
      end
      chk("lock_edge", first_lock, LC + 1);
      chk("q_after_qual", int'(bus0.q), 0);

      lock_hold = 200;
      for (int n = 0; n < 3000; n++) begin
         drive_random();
         cycle();
      end

      // Asynchronous reset between edges, checked before any clock edge.
      #2 rst = 0;
      #1;
      model_reset();
      check_all();
      #1 rst = 1;

      for (int n = 0; n < 2000; n++) begin
         drive_random();
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
